// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI command decoder and its register bank:
// FSM encoding, command-byte layout, register indices and the error byte.
package spi_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int          CMD_RW_BIT = 7;
    localparam int          REG_ID     = 0;
    localparam int          REG_CTRL   = 1;
    localparam int          LED_BIT    = 0;
    localparam logic [7:0]  ERR_BYTE   = 8'hEE;

endpackage

// File: rtl/spi_reg_bank.sv
// REG_COUNT x 8 register array: slot 0 is a read-only ID constant, one write
// port, one combinational read port, and the LED bit tapped from the control reg.
module spi_reg_bank
    import spi_regs_pkg::*;
#(
    parameter int         REG_COUNT = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] ID_VALUE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    output logic              led
);

    logic [7:0] regs [REG_COUNT];

    // Slot 0 is never written, so it stays at its reset value and is masked on read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(REG_ID))) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == ADDR_W'(REG_ID)) ? ID_VALUE : regs[raddr];
    assign led   = regs[REG_CTRL][LED_BIT];

endmodule

// File: rtl/spi_cmd_regfile.sv
// Per-frame command decoder downstream of the SPI slave byte engine: the first
// byte of a CS-low frame selects read/write and start address, later bytes burst.
module spi_cmd_regfile
    import spi_regs_pkg::*;
#(
    parameter int         REG_COUNT = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] ID_VALUE  = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_tx_data,
    output logic       o_tx_load,
    output logic       o_led,
    output logic       o_frame_err,
    output logic       o_busy
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [7:0]        tx_data_nx;
    logic              tx_load_nx;
    logic              frame_err_nx;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_raddr;
    logic [7:0]        bank_rdata;
    logic              cmd_ok;

    spi_reg_bank #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W),
        .ID_VALUE  (ID_VALUE)
    ) u_bank (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (bank_we),
        .waddr (addr),
        .wdata (i_rx_data),
        .raddr (bank_raddr),
        .rdata (bank_rdata),
        .led   (o_led)
    );

    assign cmd_ok = ~|i_rx_data[6:ADDR_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            o_tx_data   <= '0;
            o_tx_load   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            addr        <= addr_nx;
            o_tx_data   <= tx_data_nx;
            o_tx_load   <= tx_load_nx;
            o_frame_err <= frame_err_nx;
        end
    end

    // Chip-select release has priority over any byte arriving on the same edge.
    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        tx_data_nx   = o_tx_data;
        tx_load_nx   = 1'b0;
        frame_err_nx = 1'b0;
        bank_we      = 1'b0;
        bank_raddr   = addr + 1'b1;
        if (i_cs_n) begin
            state_nx   = ST_IDLE;
            tx_data_nx = '0;
        end else if (i_rx_valid) begin
            case (state)
                ST_IDLE: begin
                    bank_raddr = i_rx_data[ADDR_W-1:0];
                    if (!cmd_ok) begin
                        state_nx     = ST_ERROR;
                        frame_err_nx = 1'b1;
                        tx_data_nx   = ERR_BYTE;
                        tx_load_nx   = 1'b1;
                    end else begin
                        addr_nx = i_rx_data[ADDR_W-1:0];
                        if (i_rx_data[CMD_RW_BIT]) begin
                            state_nx   = ST_READ;
                            tx_data_nx = bank_rdata;
                            tx_load_nx = 1'b1;
                        end else begin
                            state_nx = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    bank_we = 1'b1;
                    addr_nx = addr + 1'b1;
                end
                ST_READ: begin
                    addr_nx    = addr + 1'b1;
                    tx_data_nx = bank_rdata;
                    tx_load_nx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Scoreboard bench for spi_cmd_regfile: frames are modelled byte by byte from the
// register-map rules, expected tx bytes are queued and a monitor checks each load.
module tb_spi_cmd_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       led;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic [7:0] frame_q[$];
    logic [7:0] mdl [8];

    spi_cmd_regfile dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cs_n      (cs_n),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_tx_data   (tx_data),
        .o_tx_load   (tx_load),
        .o_led       (led),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: every tx load must match the oldest expected {frame_err, byte}.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_load) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 32'(tx_data), 32'h1ff);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("tx_byte", 32'({frame_err, tx_data}), 32'(exp_item));
                end
            end else if (frame_err) begin
                check("stray_frame_err", 32'(frame_err), 32'd0);
            end
        end
    end

    task automatic model_reset();
        mdl[0] = 8'hA5;
        for (int i = 1; i < 8; i++) mdl[i] = 8'h00;
    endtask

    // Starts and ends on a falling edge; the load flag is checked one cycle after the strobe.
    task automatic send_byte(input logic [7:0] b, input logic exp_load);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        check("load_latency", 32'(tx_load), 32'(exp_load));
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic run_frame(input int max_gap);
        int mode;
        int a;
        logic [7:0] b;
        logic ld;
        mode = 0;
        a    = 0;
        cs_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < frame_q.size(); i++) begin
            b  = frame_q[i];
            ld = 1'b0;
            if (i == 0) begin
                if ((b & 8'h78) != 8'h00) begin
                    mode = 3;
                    exp_q.push_back({1'b1, 8'hEE});
                    ld = 1'b1;
                end else begin
                    a = b % 8;
                    if (b >= 8'h80) begin
                        mode = 2;
                        exp_q.push_back({1'b0, mdl[a]});
                        ld = 1'b1;
                    end else begin
                        mode = 1;
                    end
                end
            end else if (mode == 1) begin
                if (a != 0) mdl[a] = b;
                a = (a + 1) % 8;
            end else if (mode == 2) begin
                a = (a + 1) % 8;
                exp_q.push_back({1'b0, mdl[a]});
                ld = 1'b1;
            end
            send_byte(b, ld);
            check("led", 32'(led), 32'(mdl[1][0]));
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        if (frame_q.size() > 0) check("busy_in_frame", 32'(busy), 32'd1);
        cs_n = 1'b1;
        @(negedge clk);
        check("busy_after_cs", 32'(busy), 32'd0);
        check("tx_clear_after_cs", 32'(tx_data), 32'd0);
        frame_q.delete();
    endtask

    task automatic read_all();
        frame_q = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1);
    endtask

    initial begin
        rst      = 1'b1;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(negedge clk);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LED on through a write to the control register.
        frame_q = '{8'h01, 8'h01};
        run_frame(0);

        // Preload then burst read across reg2..reg4.
        frame_q = '{8'h02, 8'h11, 8'h22};
        run_frame(1);
        frame_q = '{8'h82, 8'h00, 8'h00};
        run_frame(1);

        // Write burst wrapping onto read-only reg0, then read across the wrap.
        frame_q = '{8'h07, 8'h33, 8'h44};
        run_frame(0);
        frame_q = '{8'h87, 8'h00};
        run_frame(0);

        // Bad command: error byte, following data ignored.
        frame_q = '{8'h48, 8'hFF, 8'h12};
        run_frame(1);
        read_all();

        // CS rising together with a data strobe during a write: byte dropped.
        cs_n = 1'b0;
        @(negedge clk);
        send_byte(8'h03, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cs_n     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("collide_load", 32'(tx_load), 32'd0);
        check("collide_busy", 32'(busy), 32'd0);
        check("collide_tx", 32'(tx_data), 32'd0);

        // Strobe with CS high is ignored.
        send_byte(8'h81, 1'b0);
        check("cs_high_busy", 32'(busy), 32'd0);
        read_all();

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int n;
            logic [7:0] cmd;
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) cmd = 8'($urandom_range(0, 255)) | 8'h08;
            else cmd = {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))};
            frame_q.push_back(cmd);
            for (int k = 1; k < n; k++) frame_q.push_back(8'($urandom_range(0, 255)));
            run_frame(2);
        end
        read_all();

        // Asynchronous reset in the middle of a read frame.
        frame_q = '{8'h01, 8'h01};
        run_frame(0);
        cs_n = 1'b0;
        @(negedge clk);
        exp_q.push_back({1'b0, mdl[1]});
        send_byte(8'h81, 1'b1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_tx_data", 32'(tx_data), 32'd0);
        check("arst_tx_load", 32'(tx_load), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        read_all();

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
- Byte-level command decoder and register file that sits directly downstream of the SPI slave byte engine.
- Consumes received bytes (rx byte plus 1-cycle done strobe) and the synchronized chip-select.
- Decodes per-frame read/write commands into a small register bank.
- Returns read data to the slave as the next transmit byte, and drives the board LED from a control register.

Parameters:
- REG_COUNT, 8, number of 8-bit registers; must be a power of two, from 2 to 16.
- ADDR_W, 3, address width; equals log2(REG_COUNT).
- ID_VALUE, 8'hA5, constant returned by read-only register 0.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  reset; asynchronous, active-high.
- i_cs_n  in  1  chip-select, already synchronized to i_clk, active-low.
- i_rx_valid  in  1  one-cycle strobe: a received byte is available.
- i_rx_data  in  8  received byte, valid when i_rx_valid=1.
- o_tx_data  out  8  next byte for the slave to shift out on MISO.
- o_tx_load  out  1  one-cycle strobe: o_tx_data was updated.
- o_led  out  1  LED drive; equals reg1[0].
- o_frame_err  out  1  one-cycle pulse when a bad command byte is detected.
- o_busy  out  1  high while a frame is active (state other than IDLE).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. On i_rst, all of the following are 0:
  - state = IDLE
  - addr
  - o_tx_data, o_tx_load
  - o_led
  - o_frame_err
  - all RW registers
- Register map:
  - reg0 is read-only and returns ID_VALUE.
  - reg1 is RW; bit0 drives o_led.
  - reg2..REG_COUNT-1 are RW scratch.
  - Writes to reg0 are silently dropped.
- Frame: one CS-low period. The first byte is the command:
  - bit7 = 1 means read, 0 means write.
  - bits[ADDR_W-1:0] give the start address.
  - bits[6:ADDR_W] are reserved and must be 0.
- FSM states: IDLE, WRITE, READ, ERROR.
- IDLE + i_rx_valid with a valid command:
  - Latch the address.
  - A write command goes to WRITE.
  - A read command goes to READ, and in the same edge sets o_tx_data = reg[addr] and pulses o_tx_load.
  - o_tx_data is therefore valid 1 cycle after i_rx_valid.
- IDLE + i_rx_valid with nonzero reserved bits:
  - Go to ERROR, pulse o_frame_err, set o_tx_data = 8'hEE, pulse o_tx_load.
- WRITE + i_rx_valid: reg[addr] <= i_rx_data (unless addr=0), then addr <= addr+1.
- READ + i_rx_valid:
  - The incoming byte is a don't-care.
  - addr <= addr+1; o_tx_data = reg[addr+1]; pulse o_tx_load.
- ERROR: every further byte is ignored; no tx loads.
- Address wrap: the address wraps modulo REG_COUNT (7 -> 0) in both burst directions.
- CS deassert: i_cs_n = 1 in any state returns the FSM to IDLE on the next edge and clears o_tx_data to 0 (no o_tx_load pulse). Register contents are retained.
- Simultaneous i_rx_valid and i_cs_n = 1: CS wins; the byte is dropped.
- i_rx_valid while i_cs_n = 1: ignored.
- Read-after-write inside a burst: not possible (a frame is one direction). The register value seen by a read is the value at the edge of the load.
- Reset mid-frame: immediate return to IDLE with all outputs at their reset values.
- o_led is registered; it changes 1 cycle after the write strobe.

Decomposition:
- Shared package `spi_regs_pkg` holds:
  - FSM state encoding
  - command bit positions (CMD_RW_BIT = 7)
  - register indices (REG_ID = 0, REG_CTRL = 1)
  - LED bit index
  - error byte 8'hEE
- One sub-module is natural: `spi_reg_bank`, a REG_COUNT x 8 register array with an RO slot 0, a write port and a combinational read port.
- The FSM stays in the top level.

Test Plan:
- Write LED on: CS low, bytes 0x01, 0x01, CS high -> o_led rises 1 cycle after the second i_rx_valid; o_busy falls 1 cycle after CS high.
- Burst read: preload reg2=0x11, reg3=0x22; send 0x82, 0x00, 0x00 -> o_tx_data sequence 0x11, 0x22, reg4, each with one o_tx_load pulse 1 cycle after i_rx_valid.
- Wrap and RO: write burst 0x07, 0x33, 0x44 -> reg7=0x33, reg0 still reads ID 0xA5; then read 0x87 -> tx 0x33, then 0xA5.
- Bad command: send 0x48 -> o_frame_err pulse and o_tx_data=0xEE; the next byte 0xFF writes nothing.
- CS collision: i_rx_valid and i_cs_n rising on the same cycle during WRITE -> no register change; state IDLE; o_tx_data=0.
- Async reset mid-READ: assert i_rst between clock edges -> all outputs 0 immediately; reg1=0 and o_led=0.
